// File: rtl/sub_8bits_4steps.sv
// 8-bit borrow-ripple subtractor, 4 pipeline stages of 2 bits each, valid/ready handshake.
// Define SUB_OVF_EN to add the signed-overflow output ovf_out.
module sub_8bits_4steps (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_a,
    input  logic [7:0] din_b,
    input  logic       b_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] diff_out,
    output logic       b_out,
    output logic       out_valid,
    input  logic       out_ready
`ifdef SUB_OVF_EN
    ,
    output logic       ovf_out
`endif
);

    // {borrow, diff[1:0]} of a 2-bit slice
    function automatic logic [2:0] sub2(input logic [1:0] a, input logic [1:0] b,
                                        input logic bin);
        sub2 = {1'b0, a} - {1'b0, b} - {2'b00, bin};
    endfunction

    logic [3:0] v_q, v_d;
    logic [3:0] load;
    logic       adv_1, adv_2, adv_3, adv_4;

    logic [7:2] a1_q, a1_d, b1_q, b1_d;
    logic [1:0] diff1_q, diff1_d;
    logic       bw1_q, bw1_d;

    logic [7:4] a2_q, a2_d, b2_q, b2_d;
    logic [3:0] diff2_q, diff2_d;
    logic       bw2_q, bw2_d;

    logic [7:6] a3_q, a3_d, b3_q, b3_d;
    logic [5:0] diff3_q, diff3_d;
    logic       bw3_q, bw3_d;

    logic [7:0] diff4_q, diff4_d;
    logic       bw4_q, bw4_d;
`ifdef SUB_OVF_EN
    logic       ovf4_q, ovf4_d;
`endif

    logic [2:0] s1, s2, s3, s4;

    // Advance chain runs from the output backwards; in_valid never feeds in_ready.
    always_comb begin
        adv_4    = v_q[3] && out_ready;
        adv_3    = v_q[2] && (!v_q[3] || adv_4);
        adv_2    = v_q[1] && (!v_q[2] || adv_3);
        adv_1    = v_q[0] && (!v_q[1] || adv_2);
        in_ready = !v_q[0] || adv_1;
        load     = {adv_3, adv_2, adv_1, in_valid && in_ready};
        v_d      = load | (v_q & ~{adv_4, adv_3, adv_2, adv_1});
    end

    always_comb begin
        s1 = sub2(din_a[1:0], din_b[1:0], b_in);
        s2 = sub2(a1_q[3:2], b1_q[3:2], bw1_q);
        s3 = sub2(a2_q[5:4], b2_q[5:4], bw2_q);
        s4 = sub2(a3_q[7:6], b3_q[7:6], bw3_q);

        // NOTE: every _d defaults to its _q first, so a stalled stage holds and no latch is inferred.
        a1_d = a1_q; b1_d = b1_q; diff1_d = diff1_q; bw1_d = bw1_q;
        a2_d = a2_q; b2_d = b2_q; diff2_d = diff2_q; bw2_d = bw2_q;
        a3_d = a3_q; b3_d = b3_q; diff3_d = diff3_q; bw3_d = bw3_q;
        diff4_d = diff4_q; bw4_d = bw4_q;
`ifdef SUB_OVF_EN
        ovf4_d = ovf4_q;
`endif

        if (load[0]) begin
            a1_d = din_a[7:2]; b1_d = din_b[7:2];
            diff1_d = s1[1:0]; bw1_d = s1[2];
        end
        if (load[1]) begin
            a2_d = a1_q[7:4]; b2_d = b1_q[7:4];
            diff2_d = {s2[1:0], diff1_q}; bw2_d = s2[2];
        end
        if (load[2]) begin
            a3_d = a2_q[7:6]; b3_d = b2_q[7:6];
            diff3_d = {s3[1:0], diff2_q}; bw3_d = s3[2];
        end
        if (load[3]) begin
            diff4_d = {s4[1:0], diff3_q}; bw4_d = s4[2];
`ifdef SUB_OVF_EN
            ovf4_d = (a3_q[7] != b3_q[7]) && (s4[1] != a3_q[7]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            a1_q <= '0; b1_q <= '0; diff1_q <= '0; bw1_q <= 1'b0;
            a2_q <= '0; b2_q <= '0; diff2_q <= '0; bw2_q <= 1'b0;
            a3_q <= '0; b3_q <= '0; diff3_q <= '0; bw3_q <= 1'b0;
            diff4_q <= '0; bw4_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf4_q <= 1'b0;
`endif
        end else begin
            v_q <= v_d;
            a1_q <= a1_d; b1_q <= b1_d; diff1_q <= diff1_d; bw1_q <= bw1_d;
            a2_q <= a2_d; b2_q <= b2_d; diff2_q <= diff2_d; bw2_q <= bw2_d;
            a3_q <= a3_d; b3_q <= b3_d; diff3_q <= diff3_d; bw3_q <= bw3_d;
            diff4_q <= diff4_d; bw4_q <= bw4_d;
`ifdef SUB_OVF_EN
            ovf4_q <= ovf4_d;
`endif
        end
    end

    assign diff_out  = diff4_q;
    assign b_out     = bw4_q;
    assign out_valid = v_q[3];
`ifdef SUB_OVF_EN
    assign ovf_out   = ovf4_q;
`endif

endmodule

// File: doc/sub_8bits_4steps.md
SUB_8BITS_4STEPS -- requirements
Module: sub_8bits_4steps

Interface
REQ-001 The block SHALL have no parameters; width (8) and depth (4 stages) SHALL be fixed.
REQ-002 clk  input  1  single clock; all flops SHALL be rising-edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 din_a  input  8  minuend, unsigned.
REQ-005 din_b  input  8  subtrahend, unsigned.
REQ-006 b_in  input  1  borrow-in.
REQ-007 in_valid  input  1  din_a/din_b/b_in valid this cycle.
REQ-008 in_ready  output  1  stage 1 can accept; transfer when in_valid && in_ready.
REQ-009 diff_out  output  8  result (din_a - din_b - b_in) mod 256.
REQ-010 b_out  output  1  borrow-out.
REQ-011 out_valid  output  1  diff_out/b_out/ovf_out valid.
REQ-012 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-013 ovf_out  output  1  signed overflow; present only with SUB_OVF_EN (REQ-030).

Function
REQ-014 The block SHALL be a 4-stage borrow-ripple pipeline; stage k (1..4) SHALL resolve bits [2k-1:2k-2] from that stage's incoming borrow, registering the 2 result bits, the borrow, and the unprocessed upper operand bits.
REQ-015 Each stage SHALL hold one valid bit v_k; stage 4 registers drive diff_out, b_out, ovf_out, and out_valid = v_4.
REQ-016 Advance rule: adv_4 = v_4 && out_ready; stage k<4 advances into k+1 when v_k && (!v_{k+1} || adv_{k+1}).
REQ-017 in_ready SHALL be combinational: !v_1 || adv_1; no combinational path SHALL exist from in_valid to in_ready.
REQ-018 A stage whose inputs do not advance and which itself advances SHALL clear its valid (bubble); a stalled stage SHALL hold all registers unchanged.
REQ-019 Bubbles SHALL collapse: a stalled stage 4 SHALL not prevent stages 1-3 from filling empty slots.
REQ-020 Latency: with out_ready held 1, a sample accepted at edge N SHALL appear with out_valid=1 after edge N+3 (visible in cycle N+4 window; 4 registers), throughput 1 per cycle.
REQ-021 Arithmetic: diff_out = (din_a - din_b - b_in) mod 256; b_out = 1 iff din_a < din_b + b_in (unsigned, 9-bit compare).
REQ-022 Ordering: outputs SHALL appear in acceptance order; no sample SHALL be dropped or duplicated.
REQ-023 Capacity: exactly 4 samples in flight; with out_ready=0 for >=4 accepted samples, in_ready SHALL go 0 and stay 0 until out_ready rises.
REQ-024 Simultaneous accept and emit when full: with out_ready=1, in_ready SHALL be 1 and a new sample SHALL enter while the oldest leaves.
REQ-025 Outputs under out_valid=0 SHALL hold last value (no X propagation); consumers SHALL ignore them.

Reset
REQ-026 rst=1 SHALL asynchronously clear v_1..v_4 and all data/borrow registers to 0.
REQ-027 During and after reset: out_valid=0, diff_out=0, b_out=0, ovf_out=0, in_ready=1.
REQ-028 Reset mid-operation SHALL discard all in-flight samples; no residual out_valid after deassert.
REQ-029 Reset deassertion SHALL take effect at the next rising clk; a sample presented in that cycle SHALL be accepted normally.

Configuration
REQ-030 Macro SUB_OVF_EN defined: port ovf_out SHALL exist, computed as (din_a[7] != din_b[7]) && (result[7] != din_a[7]) treating b_in as part of subtrahend, pipelined alongside sample (stage 4 register).
REQ-031 SUB_OVF_EN undefined: ovf_out port and its registers SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset: rst=1 mid-stream with 3 samples in flight -> out_valid=0, in_ready=1 immediately; no output after release.
REQ-033 Streaming: out_ready=1, din_a=0..49, din_b=10..59 (incrementing), b_in=0 -> outputs in order, each 0xF6 with b_out=1, first 4 cycles after first accept, one per cycle.
REQ-034 Arithmetic corners: (0x00,0x00,1)->0xFF,b_out=1; (0xFF,0x01,0)->0xFE,b_out=0; (0x80,0x01,0)->0x7F,b_out=0,ovf_out=1 (SUB_OVF_EN); (0x10,0x10,0)->0x00,b_out=0.
REQ-035 Backpressure: out_ready=0, 6 samples offered -> exactly 4 accepted, in_ready=0; raise out_ready -> 4 outputs in order, then remaining 2 accepted.
REQ-036 Full-and-flowing: pipeline full, out_ready=1, in_valid=1 -> in_ready=1 every cycle, no bubble.
REQ-037 Random: 10k random operands, random in_valid/out_ready -> scoreboard match on diff_out/b_out/ovf_out and order.
